// File: rtl/pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/HALTED sequencing, prioritised redirects, accepted-fetch counter.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned BRANCH/JALR targets into traps with a MISALIGN pulse.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             STALL,
    input  logic             FETCH_READY,
    input  logic             BRANCH,
    input  logic [XLEN-1:0]  PC_OFFSET,
    input  logic             JALR,
    input  logic [XLEN-1:0]  JALR_TARGET,
    input  logic             TRAP,
    input  logic             HALT,
    input  logic             RESUME,
    output logic [XLEN-1:0]  PC,
    output logic [XLEN-1:0]  PC_PLUS4,
    output logic             PC_VALID,
    output logic [CNT_W-1:0] FETCH_CNT,
    output logic             MISALIGN
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [XLEN-1:0]  pc_nxt;
    logic [XLEN-1:0]  jalr_pc;
    logic [XLEN-1:0]  branch_pc;
    logic [CNT_W-1:0] cnt_nxt;
    logic             mis_nxt;
    logic             accept;
    logic             jalr_mis;
    logic             branch_mis;

    assign jalr_pc   = JALR_TARGET & ~XLEN'(1);
    assign branch_pc = PC + PC_OFFSET;
    assign PC_PLUS4  = PC + XLEN'(4);
    assign PC_VALID  = (state == RUN);
    assign accept    = PC_VALID & FETCH_READY & ~STALL;

`ifdef PC_MISALIGN_TRAP_EN
    assign jalr_mis   = jalr_pc[1];
    assign branch_mis = |branch_pc[1:0];
`else
    assign jalr_mis   = 1'b0;
    assign branch_mis = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= BOOT;
            PC        <= RESET_VECTOR;
            FETCH_CNT <= '0;
            MISALIGN  <= 1'b0;
        end else begin
            state     <= state_nxt;
            PC        <= pc_nxt;
            FETCH_CNT <= cnt_nxt;
            MISALIGN  <= mis_nxt;
        end
    end

    // TRAP beats STALL; a halt request still lets this cycle's PC update land.
    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        mis_nxt   = 1'b0;
        cnt_nxt   = accept ? FETCH_CNT + CNT_W'(1) : FETCH_CNT;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (TRAP) begin
                    pc_nxt = TRAP_VECTOR;
                end else if (!STALL) begin
                    if (JALR) begin
                        if (jalr_mis) begin
                            pc_nxt  = TRAP_VECTOR;
                            mis_nxt = 1'b1;
                        end else begin
                            pc_nxt = jalr_pc;
                        end
                    end else if (BRANCH) begin
                        if (branch_mis) begin
                            pc_nxt  = TRAP_VECTOR;
                            mis_nxt = 1'b1;
                        end else begin
                            pc_nxt = branch_pc;
                        end
                    end else if (accept) begin
                        pc_nxt = PC_PLUS4;
                    end
                    if (HALT) begin
                        state_nxt = HALTED;
                    end
                end
            end
            HALTED: begin
                if (TRAP) begin
                    state_nxt = RUN;
                    pc_nxt    = TRAP_VECTOR;
                end else if (RESUME) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed vectors push hand-computed expectations, a monitor pops and compares.
// Expected values follow the PC_MISALIGN_TRAP_EN build setting.
module tb_pc_gen;

    logic        CLK;
    logic        RST_N;
    logic        STALL;
    logic        FETCH_READY;
    logic        BRANCH;
    logic [31:0] PC_OFFSET;
    logic        JALR;
    logic [31:0] JALR_TARGET;
    logic        TRAP;
    logic        HALT;
    logic        RESUME;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        PC_VALID;
    logic [31:0] FETCH_CNT;
    logic        MISALIGN;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;

    pc_gen dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .STALL       (STALL),
        .FETCH_READY (FETCH_READY),
        .BRANCH      (BRANCH),
        .PC_OFFSET   (PC_OFFSET),
        .JALR        (JALR),
        .JALR_TARGET (JALR_TARGET),
        .TRAP        (TRAP),
        .HALT        (HALT),
        .RESUME      (RESUME),
        .PC          (PC),
        .PC_PLUS4    (PC_PLUS4),
        .PC_VALID    (PC_VALID),
        .FETCH_CNT   (FETCH_CNT),
        .MISALIGN    (MISALIGN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic compareField(input string tag, input string field,
                                input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s %s: got %h expected %h", tag, field, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] e_pc, input logic e_valid,
                               input logic [31:0] e_cnt, input logic e_mis);
        logic [31:0] e_plus4;
        e_plus4 = e_pc + 32'd4;
        compareField(tag, "pc", PC, e_pc);
        compareField(tag, "pc_plus4", PC_PLUS4, e_plus4);
        compareField(tag, "pc_valid", {31'd0, PC_VALID}, {31'd0, e_valid});
        compareField(tag, "fetch_cnt", FETCH_CNT, e_cnt);
        compareField(tag, "misalign", {31'd0, MISALIGN}, {31'd0, e_mis});
    endtask

    // One vector per cycle: inputs driven at the falling edge, expectation is the state after the next rising edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic stall, input logic ready,
                                 input logic branch, input logic [31:0] offset,
                                 input logic jalr, input logic [31:0] jt,
                                 input logic trap, input logic halt, input logic resume,
                                 input logic [31:0] e_pc, input logic e_valid,
                                 input logic [31:0] e_cnt, input logic e_mis);
        exp_t e;
        @(negedge CLK);
        RST_N       = rst;
        STALL       = stall;
        FETCH_READY = ready;
        BRANCH      = branch;
        PC_OFFSET   = offset;
        JALR        = jalr;
        JALR_TARGET = jt;
        TRAP        = trap;
        HALT        = halt;
        RESUME      = resume;
        e.tag   = tag;
        e.pc    = e_pc;
        e.valid = e_valid;
        e.cnt   = e_cnt;
        e.mis   = e_mis;
        exp_q.push_back(e);
    endtask

    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput(mon_e.tag, mon_e.pc, mon_e.valid, mon_e.cnt, mon_e.mis);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST_N = 1'b0; STALL = 1'b0; FETCH_READY = 1'b0; BRANCH = 1'b0; PC_OFFSET = '0;
        JALR = 1'b0; JALR_TARGET = '0; TRAP = 1'b0; HALT = 1'b0; RESUME = 1'b0;

        //             tag              rst st rdy br off           jalr jt           tr ha re  pc           v cnt mis
        applyStimulus("reset_a",        0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        0, 0,  0);
        applyStimulus("reset_b",        0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        0, 0,  0);
        applyStimulus("boot_ignore",    1, 0, 1, 1, 32'h10,       1, 32'h80,       1, 1, 0, 32'h0,        1, 0,  0);
        applyStimulus("seq_4",          1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h4,        1, 1,  0);
        applyStimulus("seq_8",          1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h8,        1, 2,  0);
        applyStimulus("seq_c",          1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'hC,        1, 3,  0);
        applyStimulus("seq_10",         1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h10,       1, 4,  0);
        applyStimulus("bp_a",           1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h10,       1, 4,  0);
        applyStimulus("bp_b",           1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h10,       1, 4,  0);
        applyStimulus("stall",          1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h10,       1, 4,  0);
        applyStimulus("after_stall",    1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h14,       1, 5,  0);
        applyStimulus("branch_accept",  1, 0, 1, 1, 32'h2C,       0, 32'h0,        0, 0, 0, 32'h40,       1, 6,  0);
        applyStimulus("prio_trap",      1, 1, 1, 1, 32'h8,        1, 32'h80,       1, 0, 0, 32'h100,      1, 6,  0);
        applyStimulus("prio_jalr",      1, 0, 0, 1, 32'hFFFFFFF8, 1, 32'h205,      0, 0, 0, 32'h204,      1, 6,  0);
        applyStimulus("jalr_stalled",   1, 1, 1, 0, 32'h0,        1, 32'h400,      0, 0, 0, 32'h204,      1, 6,  0);
        applyStimulus("jalr_to_4",      1, 0, 0, 0, 32'h0,        1, 32'h5,        0, 0, 0, 32'h4,        1, 6,  0);
        applyStimulus("branch_wrap",    1, 0, 0, 1, 32'hFFFFFFF0, 0, 32'h0,        0, 0, 0, 32'hFFFFFFF4, 1, 6,  0);
        applyStimulus("seq_f8",         1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'hFFFFFFF8, 1, 7,  0);
        applyStimulus("seq_fc",         1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'hFFFFFFFC, 1, 8,  0);
        applyStimulus("seq_wrap_0",     1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        1, 9,  0);
        applyStimulus("branch_20",      1, 0, 0, 1, 32'h20,       0, 32'h0,        0, 0, 0, 32'h20,       1, 9,  0);
        applyStimulus("halt_accept",    1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h24,       0, 10, 0);
        applyStimulus("halted_a",       1, 0, 1, 1, 32'h40,       1, 32'h80,       0, 1, 0, 32'h24,       0, 10, 0);
        applyStimulus("halted_b",       1, 0, 1, 1, 32'h40,       1, 32'h80,       0, 1, 0, 32'h24,       0, 10, 0);
        applyStimulus("halted_c",       1, 0, 1, 1, 32'h40,       1, 32'h80,       0, 1, 0, 32'h24,       0, 10, 0);
        applyStimulus("resume",         1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h24,       1, 10, 0);
        applyStimulus("resume_fetch",   1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h28,       1, 11, 0);
        applyStimulus("halt_stalled",   1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h28,       1, 11, 0);
        applyStimulus("halt_idle",      1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h28,       0, 11, 0);
        applyStimulus("halted_trap",    1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h100,      1, 11, 0);
`ifdef PC_MISALIGN_TRAP_EN
        applyStimulus("misalign_jalr",  1, 0, 0, 0, 32'h0,        1, 32'h302,      0, 0, 0, 32'h100,      1, 11, 1);
        applyStimulus("misalign_clear", 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h100,      1, 11, 0);
`else
        applyStimulus("misalign_jalr",  1, 0, 0, 0, 32'h0,        1, 32'h302,      0, 0, 0, 32'h302,      1, 11, 0);
        applyStimulus("misalign_clear", 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h302,      1, 11, 0);
`endif

        // Assert reset between edges while a branch is pending; outputs must clear without a clock edge.
        @(negedge CLK);
        BRANCH    = 1'b1;
        PC_OFFSET = 32'h40;
        #2 RST_N  = 1'b0;
        #1 checkOutput("async_reset", 32'h0, 1'b0, 32'h0, 1'b0);

        applyStimulus("reset_hold",     0, 0, 1, 1, 32'h40,       0, 32'h0,        0, 0, 0, 32'h0,        0, 0,  0);
        applyStimulus("reboot",         1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        1, 0,  0);
        applyStimulus("reboot_fetch",   1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h4,        1, 1,  0);

        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V core; successor to the single-purpose branch/increment PC register. Holds the fetch PC, advances it under a valid/ready fetch handshake, and applies prioritised redirects: trap, JALR, taken branch/JAL. Adds boot/halt sequencing, stall handling and an accepted-fetch counter. Sits between the branch/execute logic and the instruction-memory interface.

## Interface
- XLEN, 32, PC and target width (≥ 8)
- RESET_VECTOR, 0, PC value loaded at reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap (truncated to XLEN)
- CNT_W, 32, width of FETCH_CNT
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- STALL  in  1  hold PC; blocks sequential advance and BRANCH/JALR
- FETCH_READY  in  1  fetch side accepts current PC
- BRANCH  in  1  taken branch/JAL; target = PC + PC_OFFSET
- PC_OFFSET  in  XLEN  signed branch offset, two's complement
- JALR  in  1  indirect jump; target = {JALR_TARGET[XLEN-1:1], 1'b0}
- JALR_TARGET  in  XLEN  raw rs1+imm sum
- TRAP  in  1  redirect to TRAP_VECTOR
- HALT  in  1  request halt
- RESUME  in  1  leave halt
- PC  out  XLEN  current fetch PC
- PC_PLUS4  out  XLEN  PC + 4, combinational, modulo 2^XLEN
- PC_VALID  out  1  PC is a valid fetch request
- FETCH_CNT  out  CNT_W  number of accepted fetches
- MISALIGN  out  1  registered one-cycle pulse (macro only; else tied 0)

## Operation
- States: BOOT, RUN, HALTED. Reset: state=BOOT, PC=RESET_VECTOR, FETCH_CNT=0, MISALIGN=0, PC_VALID=0.
- BOOT → RUN unconditionally next edge; all redirect/halt inputs ignored in BOOT.
- PC_VALID = 1 only in RUN.
- Accept = PC_VALID & FETCH_READY & !STALL; FETCH_CNT increments on accept, wraps at 2^CNT_W.
- RUN next-PC priority: TRAP → TRAP_VECTOR (overrides STALL); else STALL → hold; else JALR → cleared target; else BRANCH → PC + PC_OFFSET; else accept → PC + 4; else hold.
- BRANCH/JALR redirect regardless of FETCH_READY (squashes unaccepted fetch); counter not incremented by redirect unless accept also true that cycle.
- All additions modulo 2^XLEN; wrap from all-ones region silently.
- RUN → HALTED when HALT & !TRAP & !STALL; a same-cycle BRANCH/JALR/sequential update still applies before halting.
- HALTED: PC holds; RESUME → RUN with PC unchanged; TRAP → RUN with PC=TRAP_VECTOR (TRAP wins over RESUME). HALT in HALTED ignored.
- RST_N low at any time returns immediately to reset values, mid-redirect included.

## Timing
- Redirects and increments visible on PC one cycle after the sampling edge; zero-bubble: a taken branch sampled at edge n gives PC_VALID=1 with new PC after edge n.
- First valid fetch: PC_VALID rises one cycle after RST_N deasserts (BOOT cycle).
- PC_PLUS4 combinational from PC, no added latency.
- MISALIGN asserted in the cycle PC shows TRAP_VECTOR due to misalignment, low otherwise.

## Configuration
- PC_MISALIGN_TRAP_EN defined: a BRANCH or JALR target with bit[1]=1 (after JALR bit-0 clear; branch bits[1:0]≠0) loads TRAP_VECTOR instead and pulses MISALIGN one cycle. Applies only when that redirect is selected by priority.
- Undefined: targets loaded as computed (misaligned values allowed), MISALIGN constant 0, no extra logic.

## Test plan
- Reset/boot: RST_N low→high, FETCH_READY=1 → PC=0, PC_VALID 0 for one cycle, then PC 0,4,8; FETCH_CNT 0,1,2.
- Backpressure/stall: PC=0x10, FETCH_READY=0 two cycles then STALL=1 one cycle → PC holds 0x10, FETCH_CNT unchanged; then advances to 0x14.
- Priority: PC=0x40, TRAP=JALR=BRANCH=1, STALL=1 → PC=0x100; next JALR_TARGET=0x205 with BRANCH=1, PC_OFFSET=-8 → PC=0x204.
- Branch wrap: PC=0x0000_0004, PC_OFFSET=0xFFFF_FFF0 → PC=0xFFFF_FFF4; PC_PLUS4 at 0xFFFF_FFFC = 0.
- Halt/resume: HALT at PC=0x20 with accept → PC=0x24, PC_VALID=0 held 3 cycles; RESUME → fetch at 0x24; TRAP in HALTED → PC=0x100 RUN.
- Misalign (macro on): JALR_TARGET=0x302 → PC=0x100, MISALIGN high one cycle; macro off → PC=0x302, MISALIGN=0.
